// File: rtl/gate_tt_pkg.sv
// Shared types and limits for the gate truth-table sweeper.
package gate_tt_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      FINISH
   } tt_state_e;

   localparam int MAX_N_IN   = 4;
   localparam int MAX_SETTLE = 15;

endpackage

// File: rtl/gate_settle_timer.sv
// 4-bit down-counter that times the settle window for each swept input vector.
module gate_settle_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] value,
   output logic       zero
);

   logic [3:0] cnt_d;
   logic [3:0] cnt_q;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = value;
      end else if (cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
      if (rst) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/gate_tt_sweeper.sv
// Drives every input vector onto a combinational gate, captures its truth table
// and compares it against an expected table.
module gate_tt_sweeper
   import gate_tt_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [(1<<N_IN)-1:0]  expected,
   output logic [N_IN-1:0]       gate_in,
   input  logic                  gate_out,
   output logic                  busy,
   output logic                  done,
   output logic [(1<<N_IN)-1:0]  tt,
   output logic [(1<<N_IN)-1:0]  fail_mask,
   output logic                  pass
);

   localparam int              ROWS   = 1 << N_IN;
   localparam logic [N_IN-1:0] LAST_V = N_IN'(ROWS - 1);
   localparam logic [3:0]      RELOAD = 4'(SETTLE - 1);

   tt_state_e       state_d, state_q;
   logic [N_IN-1:0] v_d, v_q;
   logic [N_IN-1:0] gate_in_d, gate_in_q;
   logic [ROWS-1:0] exp_d, exp_q;
   logic [ROWS-1:0] tt_d, tt_q;
   logic [ROWS-1:0] fail_mask_d, fail_mask_q;
   logic            pass_d, pass_q;
   logic [ROWS-1:0] tt_next;
   logic            tmr_load;
   logic            tmr_zero;

   gate_settle_timer u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (tmr_load),
      .value (RELOAD),
      .zero  (tmr_zero)
   );

   always_comb begin
      state_d     = state_q;
      v_d         = v_q;
      gate_in_d   = gate_in_q;
      exp_d       = exp_q;
      tt_d        = tt_q;
      fail_mask_d = fail_mask_q;
      pass_d      = pass_q;
      tmr_load    = 1'b0;
      tt_next     = tt_q;
      tt_next[v_q] = gate_out;

      case (state_q)
         IDLE: begin
            if (start) begin
               exp_d       = expected;
               v_d         = '0;
               gate_in_d   = '0;
               tmr_load    = 1'b1;
               tt_d        = '0;
               fail_mask_d = '0;
               pass_d      = 1'b0;
               state_d     = DRIVE;
            end
         end
         DRIVE: begin
            if (tmr_zero) begin
               tt_d = tt_next;
               if (v_q != LAST_V) begin
                  v_d       = v_q + 1'b1;
                  gate_in_d = v_q + 1'b1;
                  tmr_load  = 1'b1;
               end else begin
                  // Verdict is formed from the final row too, so it is valid during done.
                  fail_mask_d = tt_next ^ exp_q;
                  pass_d      = ((tt_next ^ exp_q) == '0);
                  state_d     = FINISH;
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         v_q         <= '0;
         gate_in_q   <= '0;
         exp_q       <= '0;
         tt_q        <= '0;
         fail_mask_q <= '0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         v_q         <= v_d;
         gate_in_q   <= gate_in_d;
         exp_q       <= exp_d;
         tt_q        <= tt_d;
         fail_mask_q <= fail_mask_d;
         pass_q      <= pass_d;
      end
   end

   assign gate_in   = gate_in_q;
   assign busy      = (state_q == DRIVE);
   assign done      = (state_q == FINISH);
   assign tt        = tt_q;
   assign fail_mask = fail_mask_q;
   assign pass      = pass_q;

endmodule

// File: tb/tb_gate_tt_sweeper.sv
// Directed bench: three sweeper configurations, each wrapped around its own gate model.
module tb_gate_tt_sweeper;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Default configuration (N_IN=2, SETTLE=1) around an OR gate, optionally tied low.
   logic       start_def = 1'b0;
   logic [3:0] exp_def   = 4'b0;
   logic [1:0] gi_def;
   logic       go_def;
   logic       tie0      = 1'b0;
   logic       busy_def, done_def, pass_def;
   logic [3:0] tt_def, fm_def;

   assign go_def = tie0 ? 1'b0 : (gi_def[1] | gi_def[0]);

   gate_tt_sweeper #(.N_IN(2), .SETTLE(1)) u_def (
      .clk(clk), .rst(rst), .start(start_def), .expected(exp_def),
      .gate_in(gi_def), .gate_out(go_def), .busy(busy_def), .done(done_def),
      .tt(tt_def), .fail_mask(fm_def), .pass(pass_def)
   );

   // SETTLE=3 configuration around an OR gate.
   logic       start_s3 = 1'b0;
   logic [3:0] exp_s3   = 4'b1110;
   logic [1:0] gi_s3;
   logic       busy_s3, done_s3, pass_s3;
   logic [3:0] tt_s3, fm_s3;

   gate_tt_sweeper #(.N_IN(2), .SETTLE(3)) u_s3 (
      .clk(clk), .rst(rst), .start(start_s3), .expected(exp_s3),
      .gate_in(gi_s3), .gate_out(gi_s3[1] | gi_s3[0]), .busy(busy_s3), .done(done_s3),
      .tt(tt_s3), .fail_mask(fm_s3), .pass(pass_s3)
   );

   // Single-input configuration around an inverter.
   logic       start_n1 = 1'b0;
   logic [1:0] exp_n1   = 2'b01;
   logic [0:0] gi_n1;
   logic       busy_n1, done_n1, pass_n1;
   logic [1:0] tt_n1, fm_n1;

   gate_tt_sweeper #(.N_IN(1), .SETTLE(1)) u_n1 (
      .clk(clk), .rst(rst), .start(start_n1), .expected(exp_n1),
      .gate_in(gi_n1), .gate_out(~gi_n1[0]), .busy(busy_n1), .done(done_n1),
      .tt(tt_n1), .fail_mask(fm_n1), .pass(pass_n1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int       done_cnt;
      int       busy_cnt;
      int       done_k;
      logic [1:0] gi_hist [0:31];

      // Reset state
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_gate_in", 32'(gi_def), 32'h0);
      check("rst_busy", 32'(busy_def), 32'h0);
      check("rst_done", 32'(done_def), 32'h0);
      check("rst_tt", 32'(tt_def), 32'h0);
      check("rst_fail_mask", 32'(fm_def), 32'h0);
      check("rst_pass", 32'(pass_def), 32'h0);

      // Default sweep, OR gate, expected 1110
      exp_def   = 4'b1110;
      start_def = 1'b1;
      tick();
      start_def = 1'b0;
      check("or_busy_c1", 32'(busy_def), 32'h1);
      check("or_gin_c1", 32'(gi_def), 32'h0);
      tick();
      check("or_gin_c2", 32'(gi_def), 32'h1);
      tick();
      check("or_gin_c3", 32'(gi_def), 32'h2);
      tick();
      check("or_gin_c4", 32'(gi_def), 32'h3);
      check("or_done_c4", 32'(done_def), 32'h0);
      tick();
      check("or_done_c5", 32'(done_def), 32'h1);
      check("or_busy_c5", 32'(busy_def), 32'h0);
      check("or_tt", 32'(tt_def), 32'he);
      check("or_fail_mask", 32'(fm_def), 32'h0);
      check("or_pass", 32'(pass_def), 32'h1);
      tick();
      check("or_done_c6", 32'(done_def), 32'h0);
      check("or_gin_hold", 32'(gi_def), 32'h3);
      check("or_tt_hold", 32'(tt_def), 32'he);
      check("or_pass_hold", 32'(pass_def), 32'h1);

      // Gate output stuck at 0
      tie0      = 1'b1;
      start_def = 1'b1;
      tick();
      start_def = 1'b0;
      check("t0_tt_cleared", 32'(tt_def), 32'h0);
      check("t0_pass_cleared", 32'(pass_def), 32'h0);
      check("t0_gin_restart", 32'(gi_def), 32'h0);
      repeat (4) tick();
      check("t0_done", 32'(done_def), 32'h1);
      check("t0_tt", 32'(tt_def), 32'h0);
      check("t0_fail_mask", 32'(fm_def), 32'he);
      check("t0_pass", 32'(pass_def), 32'h0);
      tie0 = 1'b0;
      tick();

      // Start held through the sweep and the done cycle
      start_def = 1'b1;
      tick();
      done_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         done_cnt += int'(done_def);
         tick();
      end
      start_def = 1'b0;
      check("ign_busy_after", 32'(busy_def), 32'h0);
      for (int i = 0; i < 4; i++) begin
         done_cnt += int'(done_def);
         tick();
      end
      check("ign_done_count", 32'(done_cnt), 32'h1);
      check("ign_tt", 32'(tt_def), 32'he);
      check("ign_pass", 32'(pass_def), 32'h1);

      // Reset in the second DRIVE cycle, then a clean sweep
      start_def = 1'b1;
      tick();
      start_def = 1'b0;
      tick();
      check("rmid_gin_before", 32'(gi_def), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rmid_gin", 32'(gi_def), 32'h0);
      check("rmid_busy", 32'(busy_def), 32'h0);
      check("rmid_done", 32'(done_def), 32'h0);
      check("rmid_tt", 32'(tt_def), 32'h0);
      check("rmid_fail_mask", 32'(fm_def), 32'h0);
      check("rmid_pass", 32'(pass_def), 32'h0);
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         done_cnt += int'(done_def);
         tick();
      end
      check("rmid_no_done", 32'(done_cnt), 32'h0);
      start_def = 1'b1;
      tick();
      start_def = 1'b0;
      repeat (4) tick();
      check("rmid_rerun_done", 32'(done_def), 32'h1);
      check("rmid_rerun_pass", 32'(pass_def), 32'h1);
      tick();

      // Reset and start together: reset wins
      rst       = 1'b1;
      start_def = 1'b1;
      tick();
      rst       = 1'b0;
      start_def = 1'b0;
      check("rs_busy", 32'(busy_def), 32'h0);
      check("rs_pass", 32'(pass_def), 32'h0);
      tick();
      check("rs_busy_next", 32'(busy_def), 32'h0);

      // SETTLE=3: each vector held 3 cycles, busy 12 cycles, done on cycle 13
      start_s3 = 1'b1;
      tick();
      start_s3 = 1'b0;
      busy_cnt = 0;
      done_k   = 0;
      for (int k = 1; k <= 30; k++) begin
         gi_hist[k] = gi_s3;
         if (done_s3) begin
            done_k = k;
            break;
         end
         busy_cnt += int'(busy_s3);
         tick();
      end
      check("s3_done_cycle", 32'(done_k), 32'd13);
      check("s3_busy_cycles", 32'(busy_cnt), 32'd12);
      check("s3_gin_k3", 32'(gi_hist[3]), 32'h0);
      check("s3_gin_k4", 32'(gi_hist[4]), 32'h1);
      check("s3_gin_k9", 32'(gi_hist[9]), 32'h2);
      check("s3_gin_k12", 32'(gi_hist[12]), 32'h3);
      check("s3_tt", 32'(tt_s3), 32'he);
      check("s3_pass", 32'(pass_s3), 32'h1);
      tick();

      // N_IN=1 around an inverter, expected 01
      start_n1 = 1'b1;
      tick();
      start_n1 = 1'b0;
      done_k   = 0;
      for (int k = 1; k <= 10; k++) begin
         if (done_n1) begin
            done_k = k;
            break;
         end
         tick();
      end
      check("n1_done_cycle", 32'(done_k), 32'd3);
      check("n1_tt", 32'(tt_n1), 32'h1);
      check("n1_fail_mask", 32'(fm_n1), 32'h0);
      check("n1_pass", 32'(pass_n1), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
